// File: rtl/progmem_pkg.sv
// Shared types and constants for the program-memory access controller and
// the page-operation timer it drives.
package progmem_pkg;

   // Page command encoding offered by the programming interface
   typedef enum logic [1:0] {
      CMD_NONE       = 2'b00,
      CMD_ERASE_PROG = 2'b01,
      CMD_ERASE      = 2'b10,
      CMD_PROG       = 2'b11
   } page_cmd_e;

   // Page-operation sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ERASE = 2'b01,
      ST_PROG  = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // Bank-select codes driven to the macro
   localparam logic [1:0] BKSEL_IDLE    = 2'b00;
   localparam logic [1:0] BKSEL_WR_NRWW = 2'b01;
   localparam logic [1:0] BKSEL_WR_RWW  = 2'b10;
   localparam logic [1:0] BKSEL_NORD    = 2'b11;

   // Top address bits that identify the boot (NRWW) section
   localparam logic [2:0] NRWW_TAG_DEFAULT = 3'b111;

endpackage

// File: rtl/progmem_op_timer.sv
// Loadable down-counter that flags the last cycle of a timed operation.
// The count is loaded on entry to a timed state; expire is high while the
// count is 1, i.e. during the final cycle of the operation.
module progmem_op_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   // Load on request, otherwise count down and rest at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/progmem_rww_arbiter.sv
// Program-memory access controller: arbitrates the single flash read port
// between CPU fetch and the programmer read path, sequences page erase and
// program, and blocks reads into the section being modified.
module progmem_rww_arbiter
   import progmem_pkg::*;
#(
   parameter int         ADDR_W       = 14,
   parameter int         ERASE_CYCLES = 16,
   parameter int         PROG_CYCLES  = 16,
   parameter logic [2:0] NRWW_TAG     = NRWW_TAG_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              cpu_stall,
   input  logic              prg_rd_req,
   input  logic [ADDR_W-1:0] prg_rd_addr,
   output logic              prg_rd_gnt,
   input  logic              page_valid,
   input  logic [1:0]        page_cmd,
   input  logic [ADDR_W-1:0] page_addr,
   output logic              page_ready,
   output logic              busy,
   output logic              done,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_erase,
   output logic              mem_prog,
   output logic [1:0]        bksel
);

   localparam int MAX_CYCLES = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   state_e            state;
   state_e            next_state;
   page_cmd_e         cmd_q;
   logic [2:0]        wsec;
   logic              accept;
   logic              timer_load;
   logic [CNT_W-1:0]  timer_val;
   logic              timer_expire;

   logic              busy_now;
   logic              wr_nrww;
   logic              fetch_ok;
   logic              prg_ok;
   logic              fetch_win;
   logic              prg_win;
   logic              rd_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [1:0]        bksel_nxt;

   // Only the section tag of the page address matters to this block
   logic [ADDR_W-4:0] page_offset_unused;
   assign page_offset_unused = page_addr[ADDR_W-4:0];

   progmem_op_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .load_val(timer_val),
      .expire  (timer_expire)
   );

   // Sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, command acceptance and timer loading
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      timer_load = 1'b0;
      timer_val  = '0;
      case (state)
         ST_IDLE: begin
            if (page_valid && (page_cmd != CMD_NONE)) begin
               accept     = 1'b1;
               timer_load = 1'b1;
               if (page_cmd == CMD_PROG) begin
                  next_state = ST_PROG;
                  timer_val  = CNT_W'(PROG_CYCLES);
               end else begin
                  next_state = ST_ERASE;
                  timer_val  = CNT_W'(ERASE_CYCLES);
               end
            end
         end
         ST_ERASE: begin
            if (timer_expire) begin
               if (cmd_q == CMD_ERASE_PROG) begin
                  next_state = ST_PROG;
                  timer_load = 1'b1;
                  timer_val  = CNT_W'(PROG_CYCLES);
               end else begin
                  next_state = ST_DONE;
               end
            end
         end
         ST_PROG: begin
            if (timer_expire) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Capture the command and the section being written when a command is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q <= CMD_NONE;
         wsec  <= 3'b000;
      end else if (accept) begin
         cmd_q <= page_cmd_e'(page_cmd);
         wsec  <= page_addr[ADDR_W-1 -: 3];
      end
   end

   // Read arbitration judged on the current state: a read in the accept cycle
   // or in DONE sees an idle array; conflicts compare NRWW/RWW section class
   always_comb begin
      busy_now  = (state == ST_ERASE) || (state == ST_PROG);
      wr_nrww   = (wsec == NRWW_TAG);
      fetch_ok  = !busy_now || ((fetch_addr[ADDR_W-1 -: 3] == NRWW_TAG) != wr_nrww);
      prg_ok    = !busy_now || ((prg_rd_addr[ADDR_W-1 -: 3] == NRWW_TAG) != wr_nrww);
      fetch_win = fetch_req && fetch_ok;
      prg_win   = prg_rd_req && prg_ok && !fetch_win;
      rd_nxt    = fetch_win || prg_win;
      addr_nxt  = '0;
      if (fetch_win) begin
         addr_nxt = fetch_addr;
      end else if (prg_win) begin
         addr_nxt = prg_rd_addr;
      end
      bksel_nxt = BKSEL_IDLE;
      if (busy_now) begin
         if (!rd_nxt) begin
            bksel_nxt = BKSEL_NORD;
         end else if (wr_nrww) begin
            bksel_nxt = BKSEL_WR_NRWW;
         end else begin
            bksel_nxt = BKSEL_WR_RWW;
         end
      end
   end

   // Registered outputs; erase/program enables clear immediately on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_gnt  <= 1'b0;
         cpu_stall  <= 1'b0;
         prg_rd_gnt <= 1'b0;
         page_ready <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         mem_erase  <= 1'b0;
         mem_prog   <= 1'b0;
         bksel      <= BKSEL_IDLE;
      end else begin
         fetch_gnt  <= fetch_win;
         cpu_stall  <= fetch_req && !fetch_ok;
         prg_rd_gnt <= prg_win;
         page_ready <= (next_state == ST_IDLE);
         busy       <= (next_state == ST_ERASE) || (next_state == ST_PROG);
         done       <= (next_state == ST_DONE);
         mem_rd     <= rd_nxt;
         mem_addr   <= addr_nxt;
         mem_erase  <= (next_state == ST_ERASE);
         mem_prog   <= (next_state == ST_PROG);
         bksel      <= bksel_nxt;
      end
   end

endmodule

// File: tb/tb_progmem_rww_arbiter.sv
// Directed bench for the program-memory access controller, built with
// four-cycle erase and program so whole operations fit in a short table.
module tb_progmem_rww_arbiter;

   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              cpu_stall;
   logic              prg_rd_req;
   logic [ADDR_W-1:0] prg_rd_addr;
   logic              prg_rd_gnt;
   logic              page_valid;
   logic [1:0]        page_cmd;
   logic [ADDR_W-1:0] page_addr;
   logic              page_ready;
   logic              busy;
   logic              done;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_erase;
   logic              mem_prog;
   logic [1:0]        bksel;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic              fr;
      logic [ADDR_W-1:0] fa;
      logic              pr;
      logic [ADDR_W-1:0] pa;
      logic              pv;
      logic [1:0]        pc;
      logic [ADDR_W-1:0] pga;
      logic              e_gnt;
      logic              e_stall;
      logic              e_pgnt;
      logic              e_rd;
      logic [ADDR_W-1:0] e_addr;
      logic              e_ready;
      logic              e_busy;
      logic              e_done;
      logic              e_erase;
      logic              e_prog;
      logic [1:0]        e_bk;
      logic              chk_bk;
   } vec_t;

   vec_t vecs[24];

   progmem_rww_arbiter #(
      .ADDR_W      (ADDR_W),
      .ERASE_CYCLES(4),
      .PROG_CYCLES (4),
      .NRWW_TAG    (3'b111)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_gnt  (fetch_gnt),
      .cpu_stall  (cpu_stall),
      .prg_rd_req (prg_rd_req),
      .prg_rd_addr(prg_rd_addr),
      .prg_rd_gnt (prg_rd_gnt),
      .page_valid (page_valid),
      .page_cmd   (page_cmd),
      .page_addr  (page_addr),
      .page_ready (page_ready),
      .busy       (busy),
      .done       (done),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_erase  (mem_erase),
      .mem_prog   (mem_prog),
      .bksel      (bksel)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and move to just after the capturing edge
   task automatic applyStimulus(input vec_t v);
      fetch_req   = v.fr;
      fetch_addr  = v.fa;
      prg_rd_req  = v.pr;
      prg_rd_addr = v.pa;
      page_valid  = v.pv;
      page_cmd    = v.pc;
      page_addr   = v.pga;
      @(posedge clk);
      #1;
   endtask

   task automatic checkVector(input int idx, input vec_t v);
      checkOutput($sformatf("v%0d.fetch_gnt", idx),  16'(fetch_gnt),  16'(v.e_gnt));
      checkOutput($sformatf("v%0d.cpu_stall", idx),  16'(cpu_stall),  16'(v.e_stall));
      checkOutput($sformatf("v%0d.prg_rd_gnt", idx), 16'(prg_rd_gnt), 16'(v.e_pgnt));
      checkOutput($sformatf("v%0d.mem_rd", idx),     16'(mem_rd),     16'(v.e_rd));
      checkOutput($sformatf("v%0d.mem_addr", idx),   16'(mem_addr),   16'(v.e_addr));
      checkOutput($sformatf("v%0d.page_ready", idx), 16'(page_ready), 16'(v.e_ready));
      checkOutput($sformatf("v%0d.busy", idx),       16'(busy),       16'(v.e_busy));
      checkOutput($sformatf("v%0d.done", idx),       16'(done),       16'(v.e_done));
      checkOutput($sformatf("v%0d.mem_erase", idx),  16'(mem_erase),  16'(v.e_erase));
      checkOutput($sformatf("v%0d.mem_prog", idx),   16'(mem_prog),   16'(v.e_prog));
      if (v.chk_bk) begin
         checkOutput($sformatf("v%0d.bksel", idx), 16'(bksel), 16'(v.e_bk));
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".fetch_gnt"},  16'(fetch_gnt),  16'h0);
      checkOutput({tag, ".cpu_stall"},  16'(cpu_stall),  16'h0);
      checkOutput({tag, ".prg_rd_gnt"}, 16'(prg_rd_gnt), 16'h0);
      checkOutput({tag, ".mem_rd"},     16'(mem_rd),     16'h0);
      checkOutput({tag, ".mem_addr"},   16'(mem_addr),   16'h0);
      checkOutput({tag, ".page_ready"}, 16'(page_ready), 16'h1);
      checkOutput({tag, ".busy"},       16'(busy),       16'h0);
      checkOutput({tag, ".done"},       16'(done),       16'h0);
      checkOutput({tag, ".mem_erase"},  16'(mem_erase),  16'h0);
      checkOutput({tag, ".mem_prog"},   16'(mem_prog),   16'h0);
      checkOutput({tag, ".bksel"},      16'(bksel),      16'h0);
   endtask

   initial begin
      // Each row: inputs for one cycle, then outputs expected after that edge.
      // v0..v9: erase+program of RWW page 0x0040 (erase after v0..v3, program after v4..v7, done after v8)
      vecs[0]  = '{1'b1, 14'h0100, 1'b0, 14'h0000, 1'b1, 2'b01, 14'h0040, 1'b1, 1'b0, 1'b0, 1'b1, 14'h0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
      vecs[1]  = '{1'b1, 14'h0100, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1};
      vecs[2]  = '{1'b1, 14'h3800, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h3C00, 1'b1, 1'b0, 1'b0, 1'b1, 14'h3800, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1};
      vecs[3]  = '{1'b1, 14'h3800, 1'b1, 14'h0020, 1'b0, 2'b00, 14'h3C00, 1'b1, 1'b0, 1'b0, 1'b1, 14'h3800, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1};
      vecs[4]  = '{1'b0, 14'h0000, 1'b1, 14'h3810, 1'b0, 2'b00, 14'h3C00, 1'b0, 1'b0, 1'b1, 1'b1, 14'h3810, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
      vecs[5]  = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h3C00, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1};
      vecs[6]  = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 2'b10, 14'h3C00, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1};
      vecs[7]  = '{1'b1, 14'h0200, 1'b0, 14'h0000, 1'b1, 2'b10, 14'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1};
      vecs[8]  = '{1'b1, 14'h0200, 1'b0, 14'h0000, 1'b1, 2'b10, 14'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0};
      vecs[9]  = '{1'b1, 14'h0200, 1'b0, 14'h0000, 1'b1, 2'b10, 14'h3C00, 1'b1, 1'b0, 1'b0, 1'b1, 14'h0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
      // v10..v15: held erase-only command on boot page 0x3C00 is taken once idle
      vecs[10] = '{1'b0, 14'h0000, 1'b1, 14'h0020, 1'b1, 2'b10, 14'h3C00, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
      vecs[11] = '{1'b0, 14'h0000, 1'b1, 14'h0020, 1'b0, 2'b00, 14'h3C00, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
      vecs[12] = '{1'b1, 14'h3900, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1};
      vecs[13] = '{1'b1, 14'h3900, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1};
      vecs[14] = '{1'b1, 14'h3900, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0};
      vecs[15] = '{1'b1, 14'h3900, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h3C00, 1'b1, 1'b0, 1'b0, 1'b1, 14'h3900, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
      // v16..v17: cmd 00 ignored, fetch beats programmer read, loser served next
      vecs[16] = '{1'b1, 14'h0010, 1'b1, 14'h0020, 1'b1, 2'b00, 14'h0040, 1'b1, 1'b0, 1'b0, 1'b1, 14'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
      vecs[17] = '{1'b0, 14'h0000, 1'b1, 14'h0020, 1'b1, 2'b00, 14'h0040, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
      // v18..v23: program-only on RWW page 0x0800; 0x0900 is RWW too, so stalled
      vecs[18] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 2'b11, 14'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
      vecs[19] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1};
      vecs[20] = '{1'b1, 14'h0900, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h0800, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1};
      vecs[21] = '{1'b1, 14'h3800, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h0800, 1'b1, 1'b0, 1'b0, 1'b1, 14'h3800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
      vecs[22] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0};
      vecs[23] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 2'b00, 14'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};

      rst_n       = 1'b0;
      fetch_req   = 1'b0;
      fetch_addr  = '0;
      prg_rd_req  = 1'b0;
      prg_rd_addr = '0;
      page_valid  = 1'b0;
      page_cmd    = 2'b00;
      page_addr   = '0;
      #12;
      checkResetState("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         applyStimulus(vecs[i]);
         checkVector(i, vecs[i]);
      end

      // Reset during erase: enables drop without waiting for a clock edge
      applyStimulus('{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 2'b01, 14'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
      page_valid = 1'b0;
      page_cmd   = 2'b00;
      @(posedge clk);
      #1;
      checkOutput("midop.mem_erase_before", 16'(mem_erase), 16'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkResetState("midop");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("after_reset.c%0d.done", c),      16'(done),      16'h0);
         checkOutput($sformatf("after_reset.c%0d.mem_erase", c), 16'(mem_erase), 16'h0);
         checkOutput($sformatf("after_reset.c%0d.mem_prog", c),  16'(mem_prog),  16'h0);
         checkOutput($sformatf("after_reset.c%0d.page_ready", c), 16'(page_ready), 16'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/progmem_rww_arbiter.md
# progmem_rww_arbiter

Cycle-timed access controller for the program-memory macro. Shares the single flash read port between CPU instruction fetch and the parallel-programming read path. Sequences page erase and page program with cycle counters. Enforces read-while-write: reads into the section being modified are blocked; reads into the other section proceed. Sits between the core fetch unit / programming interface and the program-memory FSM and bank macros, and drives their RD/Erase/Prog/BkSel controls.

## Interface
- ADDR_W, 14, word address width.
- ERASE_CYCLES, 16, clock cycles mem_erase stays high (≥1).
- PROG_CYCLES, 16, clock cycles mem_prog stays high (≥1).
- NRWW_TAG, 3'b111, value of addr[13:11] that marks the NRWW (boot) section.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**.
- fetch_req  in  1  CPU fetch request (PC_RD).
- fetch_addr  in  ADDR_W  fetch word address (PC).
- fetch_gnt  out  1  fetch served this cycle.
- cpu_stall  out  1  fetch blocked by RWW conflict.
- prg_rd_req  in  1  programmer read request.
- prg_rd_addr  in  ADDR_W  programmer read address.
- prg_rd_gnt  out  1  programmer read served.
- page_valid  in  1  page command offered.
- page_cmd  in  2  00 none, 01 erase+program, 10 erase only, 11 program only.
- page_addr  in  ADDR_W  target page address.
- page_ready  out  1  command accepted when page_valid & page_ready.
- busy  out  1  page operation in progress (RDY = ~busy).
- done  out  1  one-cycle completion pulse.
- mem_rd  out  1  flash read strobe.
- mem_addr  out  ADDR_W  flash read address.
- mem_erase, mem_prog  out  1 each  macro erase / program enables.
- bksel  out  2  bank select to macro.

## Operation
- FSM: IDLE, ERASE, PROG, DONE.
- IDLE: page_ready=1.
  - Accepted cmd 01 or 10 → ERASE. Cmd 11 → PROG. Cmd 00 is ignored.
  - page_addr[13:11] is latched as wsec on acceptance. Later changes to page_addr are ignored.
- ERASE: mem_erase=1 for ERASE_CYCLES cycles. Then PROG (cmd 01) or DONE (cmd 10).
- PROG: mem_prog=1 for PROG_CYCLES cycles, then DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in ERASE and PROG only.
- Read arbitration, every cycle, any state:
  - Fixed priority: fetch over programmer read.
  - A read is eligible when idle, or when its addr[13:11] section differs from wsec (RWW rule: NRWW = tag==NRWW_TAG, RWW = otherwise).
  - Ineligible fetch → cpu_stall=1, fetch_gnt=0. Requester holds request.
  - Losing programmer read → prg_rd_gnt=0. Requester holds request.
- bksel:
  - 00 when not busy.
  - 01 when busy on NRWW with a granted read from RWW.
  - 10 when busy on RWW with a granted read from NRWW.
  - 11 when busy with no read granted.
- Counter: single down-counter of width $clog2(max(ERASE_CYCLES,PROG_CYCLES)+1). Loaded on state entry; state exits at count 1.

## Timing
- All outputs are registered.
- Reset values: all outputs 0 except page_ready=1. State=IDLE, counter=0, wsec=0.
- Read latency: request sampled at edge k → mem_rd, mem_addr, gnt valid at k+1 for one cycle. Back-to-back reads every cycle.
- Accept at edge k → mem_erase high from k+1 through k+ERASE_CYCLES.
- mem_prog is high for the following PROG_CYCLES cycles, with no gap.
- done is asserted in the cycle after the last prog cycle.
- Total 01 operation: ERASE_CYCLES+PROG_CYCLES+1 cycles, accept to done.
- page_valid during busy or DONE: not accepted, page_ready=0. Requester holds page_valid.
- Simultaneous page accept and read in IDLE: the read is judged as idle (granted). Conflicts apply from the next cycle.
- cpu_stall drops in the cycle after done.
- Reset mid-operation: mem_erase and mem_prog clear asynchronously. No done pulse. Return to IDLE.

## Structure
- progmem_pkg holds:
  - page_cmd_e
  - state_e
  - BKSEL_IDLE / BKSEL_WR_NRWW / BKSEL_WR_RWW / BKSEL_NORD constants
  - NRWW_TAG default
- Sub-module progmem_op_timer: loadable down-counter with expire flag. Reused by the SPM controller.

## Test plan
- **Reset:** rst_n low mid-ERASE → next cycle all outputs 0, page_ready=1, no done.
- **Erase+program:** ERASE/PROG_CYCLES=4, cmd 01 on page 0x0040 → mem_erase 4 cycles, mem_prog 4 cycles, done at cycle 9; busy high cycles 1–8.
- **RWW conflict:** during RWW erase, fetch 0x0100 → cpu_stall=1, bksel=11. Fetch 0x3800 → fetch_gnt, mem_addr=0x3800, bksel=10.
- **Boot write:** cmd 10 on page 0x3C00 with prg_rd 0x0020 → prg_rd_gnt, bksel=01. Fetch 0x3900 → stalled until the cycle after done.
- **Priority:** fetch 0x0010 and prg_rd 0x0020 together in idle → fetch_gnt only, mem_addr=0x0010. prg_rd granted next cycle.
- **Ignored commands:** cmd 00 with page_valid → remains IDLE. Second page_valid while busy → page_ready=0, accepted the cycle after DONE.
